instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 135 +++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues sequential fetches, buffers {pc, instr} in a 2-entry FIFO, handles redirects.
// Optional IF_PERF_CNT_EN enables the saturating backpressure cycle counter on perf_stall_cnt.
module instr_fetch #(
    parameter int PCW = 12,
    parameter int IW  = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [PCW-1:0] pc_q,
    output logic [PCW-1:0] pc_d,
    output logic [PCW-1:0] imem_addr,
    input  logic [IW-1:0]  imem_rdata,
    input  logic           redirect_valid,
    input  logic [PCW-1:0] redirect_target,
    output logic           inst_valid,
    output logic [IW-1:0]  inst_data,
    output logic [PCW-1:0] inst_pc,
    input  logic           inst_ready,
    output logic [15:0]    perf_stall_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_FLUSH
    } state_e;

    state_e         state_q, state_d;
    logic [1:0]     count_q, count_d;
    logic           inflight_q;
    logic [PCW-1:0] infl_pc_q;
    logic [PCW-1:0] fifo_pc_q   [2];
    logic [PCW-1:0] fifo_pc_d   [2];
    logic [IW-1:0]  fifo_data_q [2];
    logic [IW-1:0]  fifo_data_d [2];

    logic       pop;
    logic       push;
    logic       issue;
    logic [2:0] demand;
    logic [1:0] occ_after_pop;

    assign imem_addr  = pc_q;
    assign inst_valid = (count_q != 2'd0);
    assign inst_pc    = fifo_pc_q[0];
    assign inst_data  = fifo_data_q[0];

    assign pop    = inst_valid && inst_ready;
    // A response arriving in a redirect cycle belongs to the old stream and is dropped.
    assign push   = inflight_q && !redirect_valid;
    assign demand = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue  = (state_q == S_FETCH) && !redirect_valid && (demand < 3'd2);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: if (redirect_valid) state_d = S_FLUSH;
            S_FLUSH: if (!redirect_valid) state_d = S_FETCH;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        if (!rst) begin
            pc_d = '0;
        end else if (redirect_valid) begin
            pc_d = redirect_target;
        end else if (issue) begin
            pc_d = pc_q + PCW'(1);
        end else begin
            pc_d = pc_q;
        end
    end

    always_comb begin
        fifo_pc_d     = fifo_pc_q;
        fifo_data_d   = fifo_data_q;
        occ_after_pop = count_q - {1'b0, pop};
        count_d       = occ_after_pop;
        if (pop) begin
            fifo_pc_d[0]   = fifo_pc_q[1];
            fifo_data_d[0] = fifo_data_q[1];
        end
        if (redirect_valid) begin
            count_d = 2'd0;
        end else if (push) begin
            if (occ_after_pop == 2'd0) begin
                fifo_pc_d[0]   = infl_pc_q;
                fifo_data_d[0] = imem_rdata;
            end else begin
                fifo_pc_d[1]   = infl_pc_q;
                fifo_data_d[1] = imem_rdata;
            end
            count_d = occ_after_pop + 2'd1;
        end
    end

    // NOTE: the FIFO storage is reset too, because the head drives inst_pc/inst_data which must read zero in reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            count_q     <= 2'd0;
            inflight_q  <= 1'b0;
            infl_pc_q   <= '0;
            fifo_pc_q   <= '{default: '0};
            fifo_data_q <= '{default: '0};
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            inflight_q  <= issue;
            infl_pc_q   <= pc_q;
            fifo_pc_q   <= fifo_pc_d;
            fifo_data_q <= fifo_data_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= 16'd0;
        end else if (inst_valid && !inst_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
`else
    assign perf_stall_cnt = 16'd0;
`endif

endmodule
